// File: rtl/uart_rx.sv
// RS232 receiver: 8N1 framing, LSB first, mid-bit sampling from a per-bit clock counter.
// Good bytes are presented with a one-cycle ready strobe; a low stop bit gives a one-cycle error strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_r;
  logic             rx_s;
  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_s;
  logic             tick_s;
  logic             counting_s;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;

  // Tick decode: the start bit is timed to its middle, every later bit by a full period.
  always_comb begin
    if (state_r == START) begin
      last_s = HALF_LAST;
    end else begin
      last_s = BIT_LAST;
    end
    tick_s     = (cnt_r == last_s);
    counting_s = (state_r == START) || (state_r == DATA) || (state_r == STOP);
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) next_state_s = START;
        else       next_state_s = IDLE;
      end
      START: begin
        if (tick_s) next_state_s = rx_s ? IDLE : DATA;
        else        next_state_s = START;
      end
      DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) next_state_s = STOP;
        else                               next_state_s = DATA;
      end
      STOP: begin
        if (tick_s) next_state_s = rx_s ? IDLE : BRK;
        else        next_state_s = STOP;
      end
      // A held-low line stays here so it cannot be mistaken for new start bits.
      BRK: begin
        if (rx_s) next_state_s = IDLE;
        else      next_state_s = BRK;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register, synchronizer, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r      <= 1'b1;
      rx_s           <= 1'b1;
      state_r        <= IDLE;
      cnt_r          <= '0;
      bit_idx_r      <= 3'd0;
      shift_r        <= 8'd0;
      RxD_data       <= 8'd0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
    end else begin
      rx_meta_r      <= RxD;
      rx_s           <= rx_meta_r;
      state_r        <= next_state_s;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;

      if (counting_s && !tick_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end

      if ((state_r == START) && tick_s) begin
        bit_idx_r <= 3'd0;
      end else if ((state_r == DATA) && tick_s) begin
        shift_r   <= {rx_s, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end

      if ((state_r == STOP) && tick_s) begin
        if (rx_s) begin
          RxD_data       <= shift_r;
          RxD_data_ready <= 1'b1;
        end else begin
          RxD_frame_err  <= 1'b1;
        end
      end
    end
  end

  // Busy flag decoded straight from the state register.
  always_comb begin
    RxD_busy = (state_r != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit: a table of clean frames, then hand-written
// back-to-back, glitch, framing-error/break and mid-frame-reset sequences.
module tb_uart_rx;

  localparam int CPB = 16;
  // Ready strobe appears 154 cycles after the first clock edge that sees the start bit.
  localparam int LAT = 154;

  logic       clk;
  logic       rst;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int ready_cyc_q[$];
  logic [7:0] ready_val_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD            (RxD),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_frame_err  (RxD_frame_err),
    .RxD_busy       (RxD_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (RxD_data_ready) begin
        ready_cyc_q.push_back(cyc);
        ready_val_q.push_back(RxD_data);
      end
      if (RxD_frame_err) err_cnt = err_cnt + 1;
      if (RxD_data_ready && RxD_frame_err) both_cnt = both_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int qval(input int i);
    if (ready_val_q.size() > i) return int'(ready_val_q[i]);
    else                        return -1;
  endfunction

  function automatic int qcyc(input int i);
    if (ready_cyc_q.size() > i) return ready_cyc_q[i];
    else                        return -1;
  endfunction

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Serializer; bit period given in hundredths of a clock so fractional rates are possible.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int per_x100);
    logic [9:0] bits;
    int dur;
    bits = {stop_val, data, 1'b0};
    for (int j = 0; j < 10; j++) begin
      dur = ((j + 1) * per_x100) / 100 - (j * per_x100) / 100;
      RxD = bits[j];
      repeat (dur) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         per_x100;
  } vec_t;

  vec_t vecs[6];
  int n0;
  int e0;
  int st;

  initial begin
    // Last two rate entries are +4% and -4% relative to 16 clk/bit.
    vecs[0] = '{8'hA5, 1600};
    vecs[1] = '{8'h00, 1600};
    vecs[2] = '{8'hFF, 1600};
    vecs[3] = '{8'hC3, 1600};
    vecs[4] = '{8'h6B, 1664};
    vecs[5] = '{8'h6B, 1536};

    RxD = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_data",  int'(RxD_data), 0);
    chk("reset_ready", int'(RxD_data_ready), 0);
    chk("reset_err",   int'(RxD_frame_err), 0);
    chk("reset_busy",  int'(RxD_busy), 0);
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      n0 = ready_val_q.size();
      e0 = err_cnt;
      st = cyc + 1;
      send_frame(vecs[i].data, 1'b1, vecs[i].per_x100);
      idle(20);
      chk($sformatf("vec%0d_ready_count", i), ready_val_q.size() - n0, 1);
      chk($sformatf("vec%0d_data", i), qval(n0), int'(vecs[i].data));
      chk($sformatf("vec%0d_frame_err", i), err_cnt - e0, 0);
      chk($sformatf("vec%0d_latency", i), qcyc(n0) - st, LAT);
    end

    // Back-to-back frames with a single stop bit each.
    n0 = ready_val_q.size();
    e0 = err_cnt;
    send_frame(8'h00, 1'b1, 1600);
    send_frame(8'hFF, 1'b1, 1600);
    send_frame(8'h55, 1'b1, 1600);
    idle(20);
    chk("b2b_count",  ready_val_q.size() - n0, 3);
    chk("b2b_val0",   qval(n0), 8'h00);
    chk("b2b_val1",   qval(n0 + 1), 8'hFF);
    chk("b2b_val2",   qval(n0 + 2), 8'h55);
    chk("b2b_space1", qcyc(n0 + 1) - qcyc(n0), 160);
    chk("b2b_space2", qcyc(n0 + 2) - qcyc(n0 + 1), 160);
    chk("b2b_err",    err_cnt - e0, 0);

    // Four-cycle glitch: start bit rejected at its midpoint.
    n0 = ready_val_q.size();
    e0 = err_cnt;
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_high", int'(RxD_busy), 1);
    repeat (6) @(negedge clk);
    chk("glitch_busy_low", int'(RxD_busy), 0);
    idle(20);
    chk("glitch_no_ready", ready_val_q.size() - n0, 0);
    chk("glitch_no_err",   err_cnt - e0, 0);

    // Bad stop bit followed by a held-low line, then a good frame.
    n0 = ready_val_q.size();
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1600);
    RxD = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", int'(RxD_busy), 1);
    idle(20);
    chk("ferr_count",    err_cnt - e0, 1);
    chk("ferr_no_ready", ready_val_q.size() - n0, 0);
    chk("ferr_data_held", int'(RxD_data), 8'h55);
    chk("ferr_busy_low", int'(RxD_busy), 0);
    send_frame(8'h81, 1'b1, 1600);
    idle(20);
    chk("after_break_count", ready_val_q.size() - n0, 1);
    chk("after_break_data",  qval(n0), 8'h81);

    // Reset in the middle of data bit 4 of 0xF0 (start + d0..d3 low, d4..d7 high).
    n0 = ready_val_q.size();
    e0 = err_cnt;
    RxD = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_data",  int'(RxD_data), 0);
    chk("midrst_ready", int'(RxD_data_ready), 0);
    chk("midrst_err",   int'(RxD_frame_err), 0);
    chk("midrst_busy",  int'(RxD_busy), 0);
    idle(5 * CPB);
    chk("midrst_no_strobe", (ready_val_q.size() - n0) + (err_cnt - e0), 0);
    send_frame(8'h12, 1'b1, 1600);
    idle(20);
    chk("midrst_next_count", ready_val_q.size() - n0, 1);
    chk("midrst_next_data",  int'(RxD_data), 8'h12);

    chk("strobes_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
